// File: rtl/lm_sm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_sequencer_pkg
// Description : Shared pipeline definitions for the LM/SM multi-register
//               transfer sequencer. This package holds the opcodes, the
//               sequencer state encoding and the register-list bit mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package lm_sm_sequencer_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  // The register list is written MSB-first: bit 7 is R0 and bit 0 is R7.
  localparam logic [2:0] RL_R0_BIT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } lm_sm_state_t;

  // Converts a bit position in the register list to a register index.
  function automatic logic [2:0] bit2reg(input logic [2:0] pos);
    return RL_R0_BIT - pos;
  endfunction

  // Converts a register index to its one-hot position in the register list.
  function automatic logic [7:0] reg2onehot(input logic [2:0] idx);
    return 8'b0000_0001 << (RL_R0_BIT - idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lm_sm_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_prio_enc
// Description : Finds the highest set bit of an 8-bit register list and
//               returns the matching register index. This is the
//               lowest-numbered register, because bit 7 is R0. The block is
//               purely combinational and is shared with the hazard unit.
// Ports       : i_vec   [7:0] register list
//               o_idx   [2:0] register index of the highest set bit
//               o_valid       at least one bit of i_vec is set
// Revision    : 1.0 - initial release
// ============================================================================
module lm_sm_prio_enc
  import lm_sm_sequencer_pkg::*;
(
  input  logic [7:0] i_vec,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // The scan runs upward, so the last hit is the highest set bit.
  always_comb begin
    o_idx   = 3'd0;
    o_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i_vec[i]) begin
        o_idx   = bit2reg(3'(i));
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_sequencer
// Description : Runs LM/SM multi-register transfers beside the MEM stage.
//               The sequencer performs one register transfer per cycle in
//               ascending register order. While it runs, it stalls the
//               earlier stages. It ends the sequence with a one-cycle done
//               pulse.
// Ports       : clk, rst_n        clock / synchronous active-low reset
//               start             is_lm1 request from the EX control unit
//               instr[15:0]       IR in EX ([15:12] opcode, [7:0] list)
//               base_addr[15:0]   RA, the start memory address
//               mem_rdata, rf_rdata  combinational read data
//               busy, is_lm11     stall request / LM transfer indicator
//               mem_addr/re/we/wdata  data memory interface
//               rf_raddr/waddr/we/wdata  register file interface
//               done              end-of-sequence pulse
// Revision    : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int ADDR_STEP = 2,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       instr,
  input  logic [15:0]       base_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              is_lm11,
  output logic [15:0]       mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        rf_raddr,
  output logic [2:0]        rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done
);

  localparam logic [15:0] c_addr_step = 16'(ADDR_STEP);

  lm_sm_state_t r_state;
  lm_sm_state_t w_state_nxt;
  logic [7:0]   r_mask;
  logic [15:0]  r_addr;
  logic         r_mode;   // 0 = LM, 1 = SM

  logic [2:0]   w_cur;
  logic         w_cur_valid;
  logic [7:0]   w_mask_rest;
  logic         w_last;
  logic [3:0]   w_op;
  logic         w_accept;
  logic         w_unused;

  lm_sm_prio_enc u_prio_enc (
    .i_vec   (r_mask),
    .o_idx   (w_cur),
    .o_valid (w_cur_valid)
  );

  assign w_mask_rest = r_mask & ~reg2onehot(w_cur);
  assign w_last      = (w_mask_rest == 8'h00);
  assign w_op        = instr[15:12];
  assign w_accept    = start && ((w_op == OP_LM) || (w_op == OP_SM));
  assign w_unused    = ^{instr[11:8], w_cur_valid};

  // Data passes straight through. The strobes alone qualify it.
  assign mem_wdata = rf_rdata;
  assign rf_wdata  = mem_rdata;

  // Next state and strobes are decoded from registered state only.
  // This means start has no combinational path to any strobe.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    is_lm11     = 1'b0;
    mem_addr    = 16'h0000;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    rf_raddr    = 3'd0;
    rf_waddr    = 3'd0;
    rf_we       = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (instr[7:0] != 8'h00) ? ST_XFER : ST_FIN;
        end
      end
      ST_XFER: begin
        busy     = 1'b1;
        mem_addr = r_addr;
        if (r_mode) begin
          mem_we   = 1'b1;
          rf_raddr = w_cur;
        end else begin
          mem_re   = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = w_cur;
          is_lm11  = 1'b1;
        end
        if (w_last) begin
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= 8'h00;
      r_addr  <= 16'h0000;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mask <= instr[7:0];
            r_addr <= base_addr;
            r_mode <= instr[12];
          end
        end
        ST_XFER: begin
          r_mask <= w_mask_rest;
          r_addr <= r_addr + c_addr_step;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm_sm_sequencer
// Description : Self-checking bench for lm_sm_sequencer. The expected
//               transfer list is derived from the register list and the base
//               address. Directed cases are run first, followed by
//               randomized sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [15:0] base_addr;
  logic [15:0] mem_rdata;
  logic [15:0] rf_rdata;
  logic        busy;
  logic        is_lm11;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [2:0]  rf_raddr;
  logic [2:0]  rf_waddr;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  lm_sm_sequencer #(.ADDR_STEP(2), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .base_addr (base_addr),
    .mem_rdata (mem_rdata),
    .rf_rdata  (rf_rdata),
    .busy      (busy),
    .is_lm11   (is_lm11),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .rf_raddr  (rf_raddr),
    .rf_waddr  (rf_waddr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left between a negedge and the next posedge while the DUT is idle.
  // mid_start / rst_at name a transfer cycle (0-based), or -1 for none.
  task automatic run_seq(input logic [15:0] ins, input logic [15:0] base,
                         input int mid_start, input int rst_at, input bit start_at_done);
    int          regs[$];
    int          k;
    int          ncyc;
    bit          is_sm;
    bit          valid;
    logic [15:0] exp_addr;
    valid = (ins[15:12] == 4'b0110) || (ins[15:12] == 4'b0111);
    is_sm = ins[12];
    for (int r = 0; r < 8; r++) begin
      if (ins[7 - r]) regs.push_back(r);
    end
    k    = regs.size();
    ncyc = (k == 0) ? 1 : k;

    start     = 1'b1;
    instr     = ins;
    base_addr = base;
    chk("idle_busy", 32'(busy), 32'(0));
    @(negedge clk);
    start     = 1'b0;
    instr     = 16'($urandom);
    base_addr = 16'($urandom);

    if (!valid) begin
      #1;
      chk("badop_busy", 32'(busy), 32'(0));
      chk("badop_strobes", 32'({mem_re, mem_we, rf_we, done}), 32'(0));
      return;
    end

    for (int c = 0; c < ncyc; c++) begin
      mem_rdata = 16'($urandom);
      rf_rdata  = 16'($urandom);
      if (c == mid_start) begin
        start = 1'b1;
        instr = 16'h60FF;
      end
      #1;
      chk("busy", 32'(busy), 32'(1));
      chk("done", 32'(done), 32'(c == ncyc - 1));
      if (k == 0) begin
        chk("fin_strobes", 32'({mem_re, mem_we, rf_we, is_lm11}), 32'(0));
      end else begin
        exp_addr = base + 16'(2 * c);
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (!is_sm) begin
          chk("lm_strobes", 32'({mem_re, mem_we, rf_we, is_lm11}), 32'(4'b1011));
          chk("lm_waddr", 32'(rf_waddr), 32'(regs[c]));
          chk("lm_wdata", 32'(rf_wdata), 32'(mem_rdata));
        end else begin
          chk("sm_strobes", 32'({mem_re, mem_we, rf_we, is_lm11}), 32'(4'b0100));
          chk("sm_raddr", 32'(rf_raddr), 32'(regs[c]));
          chk("sm_wdata", 32'(mem_wdata), 32'(rf_rdata));
        end
      end
      if (c == ncyc - 1 && start_at_done) begin
        start = 1'b1;
        instr = 16'h60FF;
      end
      if (c == rst_at) rst_n = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (c == rst_at) begin
        #1;
        chk("rst_outs", 32'({busy, is_lm11, mem_addr, mem_re, mem_we,
                             rf_raddr, rf_waddr, rf_we, done}), 32'(0));
        rst_n = 1'b1;
        return;
      end
    end
    #1;
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_strobes", 32'({mem_re, mem_we, rf_we, is_lm11, done}), 32'(0));
  endtask

  initial begin
    logic [15:0] r_ins;
    logic [3:0]  op;
    rst_n     = 1'b0;
    start     = 1'b0;
    instr     = 16'h0000;
    base_addr = 16'h0000;
    mem_rdata = 16'h1234;
    rf_rdata  = 16'h5678;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs", 32'({busy, is_lm11, mem_addr, mem_re, mem_we,
                           rf_raddr, rf_waddr, rf_we, done}), 32'(0));
    rst_n = 1'b1;

    // LM R0,R2,R7 from 0x0100
    run_seq(16'h64A1, 16'h0100, -1, -1, 1'b0);
    // SM full list from 0x0200
    run_seq(16'h70FF, 16'h0200, -1, -1, 1'b0);
    // empty LM list
    run_seq(16'h6000, 16'h0300, -1, -1, 1'b0);
    // address wrap
    run_seq(16'h60C0, 16'hFFFE, -1, -1, 1'b0);
    // start during cycle 2 ignored, start during done ignored
    run_seq(16'h64A1, 16'h0400, 1, -1, 1'b1);
    // start in the cycle after done accepted
    run_seq(16'h6081, 16'h0500, -1, -1, 1'b0);
    run_seq(16'h7001, 16'h0600, -1, -1, 1'b0);
    // reset during cycle 2 of a full SM, then a new request
    run_seq(16'h70FF, 16'h0700, -1, 1, 1'b0);
    run_seq(16'h7042, 16'h0800, -1, -1, 1'b0);
    // non-LM/SM opcode ignored
    run_seq(16'h50FF, 16'h0900, -1, -1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       op = 4'($urandom_range(0, 5));
        1, 2:    op = 4'b0111;
        default: op = 4'b0110;
      endcase
      r_ins = {op, 4'($urandom), 8'($urandom)};
      if ($urandom_range(0, 7) == 0) r_ins[7:0] = 8'h00;
      run_seq(r_ins, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1,
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Executes multi-register transfers for LM (opcode 0110) and SM (opcode 0111).
- Sits beside the MEM stage and answers the EX control unit: that unit raises is_lm1 when an LM/SM reaches EX; this block then runs one register transfer per cycle.
- While running it stalls the earlier stages and drives is_lm11 back to the control unit, which uses it to steer MUX_DEST2_SEL.
- It signals completion with a one-cycle done pulse.

Parameters:
- ADDR_STEP, 2: address increment per transferred register (byte-addressed 16-bit words).
- DATA_W, 16: datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  is_lm1 from the EX control unit; request to begin.
- instr  in  16  IR of the instruction in EX; [15:12] opcode, [7:0] register list.
- base_addr  in  16  value of RA (start memory address).
- mem_rdata  in  16  data memory read data, combinational, same cycle.
- rf_rdata  in  16  register file read data for rf_raddr, combinational.
- busy  out  1  stall request to the IF/ID/RR stages.
- is_lm11  out  1  high in every LM transfer cycle.
- mem_addr  out  16  data memory address.
- mem_re  out  1  memory read enable (LM).
- mem_we  out  1  memory write enable (SM).
- mem_wdata  out  16  store data, equal to rf_rdata.
- rf_raddr  out  3  register file read index (SM).
- rf_waddr  out  3  register file write index (LM).
- rf_we  out  1  register file write enable (LM).
- rf_wdata  out  16  equal to mem_rdata.
- done  out  1  one-cycle pulse at the end of the sequence.

Behaviour:
- Reset and clocking:
  - Synchronous active-low reset: state goes to IDLE; mask, addr and mode registers go to 0.
  - Because every output decodes from these registers, all outputs are 0 in the cycle after reset is sampled low.
- State registers: state {IDLE, XFER, FIN}, mask[7:0], addr[15:0], mode (0 = LM, 1 = SM).
- Register list mapping: bit 7 is R0, bit 0 is R7. Transfers run in ascending register index, so the highest set mask bit goes first.
- IDLE:
  - Sampled start=1 with instr[15:12] in {0110, 0111}: latch mask=instr[7:0], addr=base_addr, mode=instr[12].
  - Next state is XFER if mask is nonzero, FIN if mask is 0.
  - start=1 with any other opcode is ignored.
- XFER, with cur = index of the highest set mask bit:
  - Shared outputs: busy=1; mem_addr=addr.
  - LM: mem_re=1, rf_we=1, rf_waddr=cur, is_lm11=1.
  - SM: mem_we=1, rf_raddr=cur.
  - At the clock edge: clear mask bit for cur; addr <= addr + ADDR_STEP, modulo 2^16, wrapping 0xFFFE to 0x0000.
  - If this was the last set bit: done=1 in this same cycle and next state is IDLE. Otherwise stay in XFER.
- FIN (empty list only): busy=1 and done=1 for one cycle, no memory or register-file strobes, then IDLE.
- busy is 0 in IDLE. The earlier stages resume in the cycle after done.
- Latency:
  - start sampled at edge N; first transfer in cycle N+1.
  - k registers set: done in cycle N+k.
  - Empty list: done in cycle N+1.
- start while in XFER or FIN is ignored; no queuing.
- start high in the same cycle done is high is not accepted. The block accepts only from IDLE, so a new request is honoured one cycle later.
- Reset mid-sequence:
  - Abort immediately; no further strobes after the reset edge; no done pulse.
  - Transfers already completed are not undone.
- Combinational outputs:
  - mem_wdata and rf_wdata are pure pass-through.
  - Strobe outputs are a function of registered state only; no start-to-strobe combinational path.

Decomposition:
- Shared pipeline package holds the opcode constants (OP_LM=4'b0110, OP_SM=4'b0111), the state enum, and the register-list bit mapping constant.
- One sub-module, lm_sm_prio_enc: 8-bit find-highest-set, giving a 3-bit register index and a valid flag. It is combinational and reused by the hazard unit.

Test Plan:
- LM: instr=16'h6_4A1 (list 8'hA1), base=16'h0100.
  - Cycle 1: R0 at 0x0100. Cycle 2: R2 at 0x0102. Cycle 3: R7 at 0x0104.
  - rf_we and is_lm11 high in all three cycles; done high in cycle 3; busy low in cycle 4.
- SM, full list 8'hFF, base=16'h0200:
  - 8 cycles, R0..R7 written to 0x0200..0x020E.
  - mem_wdata follows rf_rdata; is_lm11 stays 0; done in cycle 8.
- Empty list (LM, 8'h00):
  - One FIN cycle with busy=1 and done=1.
  - No mem_re, mem_we or rf_we at any time.
- Wrap: LM list 8'hC0, base=16'hFFFE.
  - R0 at 0xFFFE, R1 at 0x0000.
- start pulsed during cycle 2 of a 3-register LM:
  - Ignored; exactly 3 transfers, then IDLE.
  - A start in the cycle after done is accepted.
- rst_n low during cycle 2 of 8'hFF SM:
  - All outputs 0 from the next cycle; no done pulse.
  - Block is in IDLE and accepts a new start after rst_n returns high.
